sensor_monitor: RTL
===================

SENSOR_MONITOR -- requirements
Module: sensor_monitor

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_CNT, default 4, meaning the consecutive stable cycles needed to accept a new sensor vector (legal range 2..15).
REQ-002 The block SHALL have parameter CNT_WIDTH, default 8, meaning the width of the error event counter.
REQ-003 The block SHALL have port clk, input, 1 bit: the single system clock; all state is updated on its rising edge.
REQ-004 The block SHALL have port n_rst, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port sensors, input, 4 bits: raw, asynchronous sensor lines {W,X,Y,Z} = sensors[3:0].
REQ-006 The block SHALL have port ack, input, 1 bit: operator acknowledge of the current alarm.
REQ-007 The block SHALL have port clr_count, input, 1 bit: synchronous clear of err_count.
REQ-008 The block SHALL have port filt_sensors, output, 4 bits: debounced sensor vector.
REQ-009 The block SHALL have port alarm, output, 1 bit: level, high while an unacknowledged error exists.
REQ-010 The block SHALL have port err_event, output, 1 bit: one-cycle pulse marking each new error.
REQ-011 The block SHALL have port err_count, output, CNT_WIDTH bits: saturating count of error events.

Function
REQ-012 sensors SHALL pass through a 2-flop synchronizer before any other logic; sync output = sensors delayed 2 edges.
REQ-013 Debounce: a counter SHALL track cycles the synchronized vector differs from filt_sensors and is unchanged; reset to 0 when it equals filt_sensors or changes value.
REQ-014 filt_sensors SHALL load the synchronized vector on the edge at which that counter would reach DEBOUNCE_CNT; pulses shorter than DEBOUNCE_CNT cycles SHALL never reach filt_sensors.
REQ-015 err_cond SHALL be combinational: filt[0] | (filt[1] & (filt[3] | filt[2])).
REQ-016 The FSM SHALL have states IDLE, ALARM, HOLD, with alarm = 1 only in ALARM.
REQ-017 IDLE -> ALARM when err_cond = 1; err_event SHALL be 1 on the cycle after that transition edge only.
REQ-018 ALARM with ack = 1 SHALL go to HOLD if err_cond = 1, else to IDLE; ALARM with ack = 0 SHALL stay in ALARM regardless of err_cond (latched alarm).
REQ-019 HOLD -> IDLE when err_cond = 0; no new event while in HOLD.
REQ-020 ack SHALL be ignored in IDLE and HOLD.
REQ-021 Latency: a stable input change causing err_cond SHALL raise alarm 2 + DEBOUNCE_CNT + 1 edges after sensors is first sampled at its new value.
REQ-022 err_count SHALL increment by 1 on each IDLE->ALARM transition and saturate at 2^CNT_WIDTH-1 without wrapping.
REQ-023 When clr_count = 1 and an increment coincide, err_count SHALL become 0 (clear wins).

Reset
REQ-024 n_rst = 0 SHALL immediately force synchronizer flops, filt_sensors and the debounce counter to 0, FSM to IDLE, and alarm, err_event and err_count to 0.
REQ-025 Reset asserted mid-alarm SHALL drop alarm without an ack; after release, an error still present SHALL be re-detected as a new event after full latency.

Configuration
REQ-026 With macro SENSOR_MONITOR_CNT_EN defined, the err_count counter and clr_count logic SHALL be built as specified.
REQ-027 Without SENSOR_MONITOR_CNT_EN, err_count SHALL be tied to 0, clr_count ignored, and all other behaviour unchanged.

Verification
REQ-028 Defaults, sensors 0000 -> 0010 (Y only) held 20 cycles -> filt_sensors = 0010, alarm stays 0, err_count = 0.
REQ-029 sensors 0000 -> 0001 held -> alarm = 1 exactly 7 edges after the change, err_event high 1 cycle, err_count = 1.
REQ-030 sensors 0110 pulse of 3 cycles, then back to 0000 -> filt_sensors stays 0000, no alarm, no err_event.
REQ-031 Alarm active, error still present, ack = 1 for 1 cycle -> HOLD, alarm = 0; sensors -> 0000 -> IDLE; sensors -> 1010 -> second event, err_count = 2.
REQ-032 CNT_WIDTH = 2, 5 error events -> err_count = 3; clr_count = 1 on the same cycle as the 6th increment -> err_count = 0.
REQ-033 n_rst pulsed low while in ALARM with sensors = 0001 held -> all outputs 0 at once; alarm = 1 again 7 edges after release with err_count = 1.

Source files
------------

// File: rtl/sensor_monitor.sv
// Sensor monitor: synchronizes and debounces four raw sensor lines, derives an
// error condition, and runs a latched-alarm FSM with an acknowledge/hold path.
// Optional saturating error-event counter is built when SENSOR_MONITOR_CNT_EN
// is defined; otherwise err_count is tied to zero and clr_count is ignored.
module sensor_monitor #(
  parameter int unsigned DEBOUNCE_CNT = 4,
  parameter int unsigned CNT_WIDTH    = 8
) (
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic [3:0]           sensors,
  input  logic                 ack,
  input  logic                 clr_count,
  output logic [3:0]           filt_sensors,
  output logic                 alarm,
  output logic                 err_event,
  output logic [CNT_WIDTH-1:0] err_count
);

  localparam logic [3:0] DbLimit = 4'(DEBOUNCE_CNT);

  typedef enum logic [1:0] {
    StIdle,
    StAlarm,
    StHold
  } state_e;

  logic [3:0] sync1_q, sync2_q;
  logic [3:0] prev_q;
  logic [3:0] filt_q, filt_d;
  logic [3:0] db_cnt_q, db_cnt_d;
  logic [3:0] run_len;
  logic       err_cond;
  logic       inc;
  state_e     state_q;
  logic       alarm_q;
  logic       err_event_q;

  // Two-flop synchronizer; prev_q remembers the last synchronized value so a
  // change can restart the stability run.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
      prev_q  <= '0;
    end else begin
      sync1_q <= sensors;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  // Debounce: count consecutive cycles of a stable value differing from filt;
  // the cycle in which a new value first appears counts as the first one.
  always_comb begin
    filt_d   = filt_q;
    db_cnt_d = db_cnt_q;
    run_len  = '0;
    if (sync2_q == filt_q) begin
      db_cnt_d = '0;
    end else begin
      run_len = (sync2_q != prev_q) ? 4'd1 : db_cnt_q + 4'd1;
      if (run_len == DbLimit) begin
        filt_d   = sync2_q;
        db_cnt_d = '0;
      end else begin
        db_cnt_d = run_len;
      end
    end
  end

  // Debounce state registers.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      filt_q   <= '0;
      db_cnt_q <= '0;
    end else begin
      filt_q   <= filt_d;
      db_cnt_q <= db_cnt_d;
    end
  end

  // Error when Z, or Y together with W or X.
  assign err_cond = filt_q[0] | (filt_q[1] & (filt_q[3] | filt_q[2]));
  assign inc      = (state_q == StIdle) & err_cond;

  // Alarm FSM with registered outputs; an alarm stays latched until acked.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q     <= StIdle;
      alarm_q     <= 1'b0;
      err_event_q <= 1'b0;
    end else begin
      err_event_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (err_cond) begin
            state_q     <= StAlarm;
            alarm_q     <= 1'b1;
            err_event_q <= 1'b1;
          end
        end
        StAlarm: begin
          if (ack) begin
            alarm_q <= 1'b0;
            state_q <= err_cond ? StHold : StIdle;
          end
        end
        StHold: begin
          if (!err_cond) begin
            state_q <= StIdle;
          end
        end
        default: begin
          state_q <= StIdle;
          alarm_q <= 1'b0;
        end
      endcase
    end
  end

`ifdef SENSOR_MONITOR_CNT_EN
  logic [CNT_WIDTH-1:0] err_count_q, err_count_d;

  // Saturating event counter; a clear beats a coincident increment.
  always_comb begin
    err_count_d = err_count_q;
    if (clr_count) begin
      err_count_d = '0;
    end else if (inc && (err_count_q != '1)) begin
      err_count_d = err_count_q + CNT_WIDTH'(1);
    end
  end

  // Event counter register.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      err_count_q <= '0;
    end else begin
      err_count_q <= err_count_d;
    end
  end

  assign err_count = err_count_q;
`else
  logic unused_cnt;
  assign unused_cnt = clr_count ^ inc;
  assign err_count  = '0;
`endif

  assign filt_sensors = filt_q;
  assign alarm        = alarm_q;
  assign err_event    = err_event_q;

endmodule
